// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage core; in-order prefetch FIFO feeding the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the perf_bubble_cnt / perf_drop_cnt counter ports.

// sync_fifo: generic single-clock FIFO with synchronous flush; DEPTH must be a power of two.
// Latency: an entry written on one edge is at the head from the next cycle; no bypass.
// Backpressure: inRdy drops when full, outVld drops when empty; clear empties in one cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inVld,
  output logic                     inRdy,
  input  logic [WIDTH-1:0]         inDat,
  output logic                     outVld,
  input  logic                     outRdy,
  output logic [WIDTH-1:0]         outDat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             push;
  logic             pop;

  assign inRdy  = (count != FULL_CNT);
  assign outVld = (count != '0);
  assign outDat = mem[rdPtr];
  assign push   = inVld && inRdy;
  assign pop    = outVld && outRdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= inDat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end
endmodule

// fetch_stage: drives PCF, issues imem requests, buffers in-order responses, loads IF/ID.
// Latency: 2 cycles from request acceptance to InstrD with a 1-cycle memory (no bypass).
// Backpressure: requests gated by FIFO credit (fifo_count+outstanding); stall_d holds IF/ID.
module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            instr_valid_d,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetchEntry_t;

  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] rspPc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   dropCnt;
  logic [CW-1:0]   fifoCount;
  logic [CW:0]     inFlight;
  logic            reqFire;
  logic            rspDrop;
  logic            rspPush;
  logic            fifoInRdy;
  logic            fifoOutVld;
  logic            fifoPop;
  fetchEntry_t     pushEntry;
  fetchEntry_t     headEntry;

  // Reserving FIFO space at request time guarantees every response has a slot.
  assign inFlight       = {1'b0, fifoCount} + {1'b0, outstanding};
  assign imem_req_valid = !redirect_valid && (inFlight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pcF;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A response landing in the redirect cycle belongs to the old path as well.
  assign rspDrop   = imem_rsp_valid && (redirect_valid || (dropCnt != '0));
  assign rspPush   = imem_rsp_valid && !rspDrop;
  assign fifoPop   = !redirect_valid && !stall_d && fifoOutVld;
  assign pushEntry = '{instr: imem_rsp_data, pc: rspPc};

  sync_fifo #(
    .WIDTH ($bits(fetchEntry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk    (clk),
    .reset  (reset),
    .clear  (redirect_valid),
    .inVld  (rspPush),
    .inRdy  (fifoInRdy),
    .inDat  (pushEntry),
    .outVld (fifoOutVld),
    .outRdy (fifoPop),
    .outDat (headEntry),
    .count  (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF         <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      if (redirect_valid) begin
        pcF <= redirect_pc;
      end else if (reqFire) begin
        pcF <= pcF + XLEN'(4);
      end

      if (redirect_valid) begin
        rspPc <= redirect_pc;
      end else if (rspPush) begin
        rspPc <= rspPc + XLEN'(4);
      end

      if (reqFire && !imem_rsp_valid) begin
        outstanding <= outstanding + CW'(1);
      end else if (!reqFire && imem_rsp_valid) begin
        outstanding <= outstanding - CW'(1);
      end

      if (redirect_valid) begin
        dropCnt <= outstanding - CW'(imem_rsp_valid);
      end else if (rspDrop) begin
        dropCnt <= dropCnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_d <= 1'b0;
      InstrD        <= NOP_INSTR;
      PCD           <= '0;
      PCPlus4D      <= '0;
    end else if (redirect_valid) begin
      instr_valid_d <= 1'b0;
      InstrD        <= NOP_INSTR;
    end else if (!stall_d) begin
      if (fifoOutVld) begin
        instr_valid_d <= 1'b1;
        InstrD        <= headEntry.instr;
        PCD           <= headEntry.pc;
        PCPlus4D      <= headEntry.pc + XLEN'(4);
      end else begin
        instr_valid_d <= 1'b0;
        InstrD        <= NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rspPush && !fifoInRdy))
        else $error("fetch_stage: response arrived with prefetch FIFO full");
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubble_cnt <= '0;
      perf_drop_cnt   <= '0;
    end else begin
      if (!redirect_valid && !stall_d && !fifoOutVld) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
      if (rspDrop) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order instruction memory of configurable latency.
module tb_fetch_stage;
  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        instr_valid_d;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;
  logic [31:0] qAddr [$];
  int          qDue  [$];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .instr_valid_d  (instr_valid_d),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // One clock: sample the handshake before the edge, then update the memory model after it.
  task automatic step();
    logic        fire;
    logic        rspTaken;
    logic [31:0] a;
    @(negedge clk);
    fire     = imem_req_valid && imem_req_ready && !reset;
    a        = imem_req_addr;
    rspTaken = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      qAddr.delete();
      qDue.delete();
    end else begin
      if (rspTaken) begin
        void'(qAddr.pop_front());
        void'(qDue.pop_front());
      end
      if (fire) begin
        qAddr.push_back(a);
        qDue.push_back(cyc + lat - 1);
      end
    end
    if (qAddr.size() > 0 && qDue[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(qAddr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  initial begin
    int waitCnt;
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_d        = 1'b0;
    step();
    step();

    check("rst_valid", instr_valid_d, 0);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 0);
    check("rst_pcplus4", PCPlus4D, 0);
    check("rst_addr", imem_req_addr, 0);
    check("rst_req_valid", imem_req_valid, 1);

    // Straight-line fetch, 1-cycle memory.
    reset = 1'b0;
    imem_req_ready = 1'b1;
    step();
    check("t1_lat_a_valid", instr_valid_d, 0);
    step();
    check("t1_lat_b_valid", instr_valid_d, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_valid", instr_valid_d, 1);
      check("t1_pcd", PCD, 32'(4 * i));
      check("t1_instr", InstrD, memWord(32'(4 * i)));
      check("t1_pcplus4", PCPlus4D, 32'(4 * i + 4));
    end

    // Stall: IF/ID frozen, credit exhausts, then drains in order.
    stall_d = 1'b1;
    step();
    check("t2_hold_pcd0", PCD, 32'h8);
    check("t2_hold_instr0", InstrD, memWord(32'h8));
    step();
    check("t2_hold_pcd1", PCD, 32'h8);
    check("t2_credit_block1", imem_req_valid, 0);
    step();
    check("t2_hold_pcd2", PCD, 32'h8);
    check("t2_hold_valid2", instr_valid_d, 1);
    check("t2_credit_block2", imem_req_valid, 0);
    check("t2_addr_hold", imem_req_addr, 32'h1C);
    stall_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_drain_valid", instr_valid_d, 1);
      check("t2_drain_pcd", PCD, 32'(32'hC + 4 * i));
      check("t2_drain_instr", InstrD, memWord(32'(32'hC + 4 * i)));
    end

    // Reset mid-stream with the FIFO partly full.
    reset = 1'b1;
    step();
    check("t6_valid", instr_valid_d, 0);
    check("t6_instr", InstrD, NOP);
    check("t6_pcd", PCD, 0);
    check("t6_pcplus4", PCPlus4D, 0);
    check("t6_addr", imem_req_addr, 0);
    reset = 1'b0;

    // Memory not ready: address frozen, bubbles.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_addr", imem_req_addr, 0);
      check("t5_req_valid", imem_req_valid, 1);
      check("t5_bubble", instr_valid_d, 0);
      check("t5_instr_nop", InstrD, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    check("t5_perf_bubble", perf_bubble_cnt, 5);
`endif

    // Redirect with two requests outstanding and a response in the same cycle, 3-cycle memory.
    lat = 3;
    imem_req_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    step();
    check("t3_rsp_present", imem_rsp_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    imem_req_ready = 1'b1;
    #1;
    check("t3_no_req_on_redirect", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    check("t3_flush_valid", instr_valid_d, 0);
    check("t3_flush_instr", InstrD, NOP);
    check("t3_new_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_wait_valid", instr_valid_d, 0);
    end
    step();
    check("t3_first_valid", instr_valid_d, 1);
    check("t3_first_pcd", PCD, 32'h100);
    check("t3_first_instr", InstrD, memWord(32'h100));
    check("t3_first_pcplus4", PCPlus4D, 32'h104);
`ifdef FETCH_PERF_CNT_EN
    check("t3_perf_drop", perf_drop_cnt, 2);
`endif

    // Redirect and stall together: flush wins, fetch resumes at the target.
    stall_d        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    check("t4_flush_valid", instr_valid_d, 0);
    check("t4_flush_instr", InstrD, NOP);
    check("t4_new_addr", imem_req_addr, 32'h200);
    stall_d        = 1'b0;
    redirect_valid = 1'b0;
    waitCnt = 0;
    while (!instr_valid_d && waitCnt < 12) begin
      step();
      waitCnt++;
    end
    check("t4_resume_valid", instr_valid_d, 1);
    check("t4_resume_pcd", PCD, 32'h200);
    check("t4_resume_instr", InstrD, memWord(32'h200));
    check("t4_resume_pcplus4", PCPlus4D, 32'h204);
`ifdef FETCH_PERF_CNT_EN
    check("t4_perf_drop", perf_drop_cnt, 4);
`endif

    step();
    check("t4_next_pcd", PCD, 32'h204);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
